// File: rtl/rx_eq_pkg.sv
// Shared definitions for the receive equalizer: sizes, FSM states, default
// inverse-impulse-response coefficients and the Q1.15 multiply-truncate helper.
package rx_eq_pkg;

    localparam int TAPS = 31;
    localparam int W    = 16;
    localparam int FRAC = 15;
    localparam int AW   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [W-1:0] COEF_DEFAULT [0:TAPS-1] = '{
        16'h0010, 16'hFFE8, 16'h0024, 16'hFFC8, 16'h0050, 16'hFF90, 16'h00A0, 16'hFF20,
        16'h0140, 16'hFE40, 16'h0280, 16'hFC80, 16'h0500, 16'hF800, 16'h1000, 16'h6000,
        16'h1000, 16'hF800, 16'h0500, 16'hFC80, 16'h0280, 16'hFE40, 16'h0140, 16'hFF20,
        16'h00A0, 16'hFF90, 16'h0050, 16'hFFC8, 16'h0024, 16'hFFE8, 16'h0010
    };

    // Full signed product, arithmetic shift back to Q1.15, keep the low W bits.
    function automatic logic [W-1:0] mac_term(input logic [W-1:0] sample,
                                              input logic [W-1:0] coef);
        logic signed [2*W-1:0] prod_s;
        prod_s = $signed(sample) * $signed(coef);
        prod_s = prod_s >>> FRAC;
        return prod_s[W-1:0];
    endfunction

endpackage

// File: rtl/rx_coef_bank.sv
// Run-time writable coefficient register file: synchronous write, asynchronous
// read by tap index, reloaded with the default response on reset.
module rx_coef_bank
    import rx_eq_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] coef_r [TAPS];

    // Coefficient storage with default reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++) begin
                coef_r[k] <= COEF_DEFAULT[k];
            end
        end else if (we) begin
            coef_r[waddr] <= wdata;
        end
    end

    assign rdata = coef_r[raddr];

endmodule

// File: rtl/rx_eq_scheduler.sv
// 31-tap equalizer sequencer sharing one multiplier and accumulator across all
// taps, with valid/ready on both sides and an IDLE-only coefficient write port.
module rx_eq_scheduler
    import rx_eq_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  symb_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  symb_out,
    input  logic          coef_we,
    input  logic [AW-1:0] coef_addr,
    input  logic [W-1:0]  coef_wdata,
    output logic          busy
);

    state_e        state_r;
    state_e        state_next_s;
    logic [AW-1:0] tap_r;
    logic [W-1:0]  acc_r;
    logic [W-1:0]  dly_r [TAPS];
    logic [W-1:0]  coef_rd_s;
    logic [W-1:0]  term_s;
    logic [W-1:0]  acc_sum_s;
    logic          in_ready_s;
    logic          accept_s;
    logic          coef_we_s;
    logic          last_tap_s;
    logic          out_valid_r;
    logic [W-1:0]  symb_out_r;
    logic          busy_r;

    // A write in the same cycle as an accept lands before MAC reads tap 0.
    rx_coef_bank u_coef_bank (
        .clk   (clk),
        .reset (reset),
        .we    (coef_we_s),
        .waddr (coef_addr),
        .wdata (coef_wdata),
        .raddr (tap_r),
        .rdata (coef_rd_s)
    );

    assign last_tap_s = (tap_r == AW'(TAPS - 1));
    assign term_s     = mac_term(dly_r[tap_r], coef_rd_s);
    assign acc_sum_s  = acc_r + term_s;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = MAC;
                else          state_next_s = IDLE;
            end
            MAC: begin
                if (last_tap_s) state_next_s = DONE;
                else            state_next_s = MAC;
            end
            DONE: begin
                if (accept_s)       state_next_s = MAC;
                else if (out_ready) state_next_s = IDLE;
                else                state_next_s = DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // FSM outputs: handshake and write qualification.
    always_comb begin
        in_ready_s = 1'b0;
        case (state_r)
            IDLE:    in_ready_s = 1'b1;
            DONE:    in_ready_s = out_ready;
            default: in_ready_s = 1'b0;
        endcase
        accept_s  = in_valid & in_ready_s;
        coef_we_s = coef_we & (state_r == IDLE) & (coef_addr < AW'(TAPS));
    end

    // Delay line, tap counter and accumulator.
    always_ff @(posedge clk) begin
        if (reset) begin
            tap_r <= '0;
            acc_r <= '0;
            for (int k = 0; k < TAPS; k++) begin
                dly_r[k] <= '0;
            end
        end else if (accept_s) begin
            dly_r[0] <= symb_in;
            for (int k = 1; k < TAPS; k++) begin
                dly_r[k] <= dly_r[k-1];
            end
            tap_r <= '0;
            acc_r <= '0;
        end else if (state_r == MAC) begin
            acc_r <= acc_sum_s;
            if (last_tap_s) tap_r <= '0;
            else            tap_r <= tap_r + 5'd1;
        end
    end

    // Registered result, valid flag and busy indication.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            symb_out_r  <= '0;
            busy_r      <= 1'b0;
        end else begin
            busy_r <= (state_next_s != IDLE);
            if ((state_r == MAC) && last_tap_s) begin
                out_valid_r <= 1'b1;
                symb_out_r  <= acc_sum_s;
            end else if ((state_r == DONE) && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign symb_out  = symb_out_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_rx_eq_scheduler.sv
// Self-checking bench for rx_eq_scheduler: randomized samples and coefficients
// compared against a plain-arithmetic FIR model of the equalizer.
module tb_rx_eq_scheduler;
    import rx_eq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] symb_in = 16'h0000;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] symb_out;
    logic        coef_we = 1'b0;
    logic [4:0]  coef_addr = 5'd0;
    logic [15:0] coef_wdata = 16'h0000;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_coef [TAPS];
    logic [15:0] m_hist [TAPS];

    rx_eq_scheduler dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .symb_in    (symb_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .symb_out   (symb_out),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void m_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_coef[k] = COEF_DEFAULT[k];
            m_hist[k] = 16'h0000;
        end
    endfunction

    function automatic void m_push(input logic [15:0] x);
        for (int k = TAPS - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = x;
    endfunction

    // FIR sum: each term floor(sample*coef / 2^15), everything modulo 2^16.
    function automatic logic [15:0] m_expect();
        longint p;
        longint acc;
        acc = 0;
        for (int k = 0; k < TAPS; k++) begin
            p = longint'($signed(m_hist[k])) * longint'($signed(m_coef[k]));
            p = p >>> 15;
            acc = (acc + (p & 64'hFFFF)) % 65536;
        end
        return acc[15:0];
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        m_reset();
    endtask

    task automatic write_coef(input logic [4:0] addr, input logic [15:0] data);
        coef_we = 1'b1;
        coef_addr = addr;
        coef_wdata = data;
        step();
        coef_we = 1'b0;
        if (addr < 5'd31) m_coef[addr] = data;
    endtask

    // Accept one sample from IDLE, check latency and value, then consume after 'hold' cycles.
    task automatic run_sample(input logic [15:0] x, input int hold, output logic [15:0] got);
        int n;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL idle_in_ready: got %b want 1", in_ready);
        end
        in_valid = 1'b1;
        symb_in = x;
        step();
        in_valid = 1'b0;
        m_push(x);
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        n_cmp++;
        if (n != 31) begin
            n_err++;
            $display("FAIL latency: got %0d cycles want 31", n);
        end
        got = symb_out;
        n_cmp++;
        if (symb_out !== m_expect()) begin
            n_err++;
            $display("FAIL result: got %h want %h", symb_out, m_expect());
        end
        repeat (hold) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_idle();
        do_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || symb_out !== 16'h0000 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b d=%h b=%b r=%b want 0 0000 0 1",
                     out_valid, symb_out, busy, in_ready);
        end
    endtask

    task automatic test_default_random();
        logic [15:0] got;
        for (int i = 0; i < 4; i++) run_sample(16'($urandom), int'($urandom_range(0, 2)), got);
    endtask

    task automatic test_reset_mid_mac();
        in_valid = 1'b1;
        symb_in = 16'h4321;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_in_mac: got %b want 1", busy);
        end
        do_reset();
        n_cmp++;
        if (out_valid !== 1'b0 || symb_out !== 16'h0000 || busy !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_mac: got v=%b d=%h b=%b r=%b want 0 0000 0 1",
                     out_valid, symb_out, busy, in_ready);
        end
        n_cmp++;
        if (dut.u_coef_bank.coef_r[5] !== COEF_DEFAULT[5]) begin
            n_err++;
            $display("FAIL coef5_default: got %h want %h", dut.u_coef_bank.coef_r[5], COEF_DEFAULT[5]);
        end
        n_cmp++;
        repeat (2) step();
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL no_stale_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_single_tap();
        logic [15:0] got;
        for (int k = 0; k < TAPS; k++) write_coef(5'(k), (k == 0) ? 16'h4000 : 16'h0000);
        run_sample(16'h2000, 0, got);
        n_cmp++;
        if (got !== 16'h1000) begin
            n_err++;
            $display("FAIL single_tap: got %h want 1000", got);
        end
    endtask

    task automatic test_delay_align();
        logic [15:0] got;
        logic [15:0] feed [4];
        logic [15:0] want [4];
        feed = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
        want = '{16'h0000, 16'h0000, 16'h0000, 16'h00FF};
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(5'(k), (k == 3) ? 16'h7FFF : 16'h0000);
        for (int i = 0; i < 4; i++) begin
            run_sample(feed[i], 0, got);
            n_cmp++;
            if (got !== want[i]) begin
                n_err++;
                $display("FAIL delay_align[%0d]: got %h want %h", i, got, want[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] held;
        int n;
        write_coef(5'd0, 16'($urandom));
        write_coef(5'd7, 16'($urandom));
        x = 16'($urandom);
        in_valid = 1'b1;
        symb_in = x;
        step();
        in_valid = 1'b0;
        m_push(x);
        held = m_expect();
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        n_cmp++;
        if (n != 31) begin
            n_err++;
            $display("FAIL bp_latency: got %0d want 31", n);
        end
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (symb_out !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold[%0d]: got d=%h v=%b r=%b want %h 1 0",
                         i, symb_out, out_valid, in_ready, held);
            end
            step();
        end
        y = 16'($urandom);
        in_valid = 1'b1;
        symb_in = y;
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_in_ready: got %b want 1", in_ready);
        end
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        m_push(y);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_handoff: got v=%b b=%b want 0 1", out_valid, busy);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        n_cmp++;
        if (n != 31) begin
            n_err++;
            $display("FAIL b2b_latency: got %0d want 31", n);
        end
        n_cmp++;
        if (symb_out !== m_expect()) begin
            n_err++;
            $display("FAIL b2b_result: got %h want %h", symb_out, m_expect());
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_write_busy();
        logic [15:0] got;
        logic [15:0] a;
        int n;
        a = 16'($urandom);
        write_coef(5'd0, a);
        in_valid = 1'b1;
        symb_in = 16'($urandom);
        step();
        in_valid = 1'b0;
        m_push(symb_in);
        coef_we = 1'b1;
        coef_addr = 5'd0;
        coef_wdata = ~a;
        repeat (3) step();
        coef_we = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        n_cmp++;
        if (symb_out !== m_expect()) begin
            n_err++;
            $display("FAIL write_busy_result: got %h want %h", symb_out, m_expect());
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        write_coef(5'd31, 16'($urandom));
        run_sample(16'($urandom), 0, got);
        run_sample(16'($urandom), 1, got);
    endtask

    task automatic test_wrap();
        logic [15:0] got;
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(5'(k), (k < 2) ? 16'h7FFF : 16'h0000);
        run_sample(16'h7FFF, 0, got);
        run_sample(16'h7FFF, 0, got);
        n_cmp++;
        if (got !== 16'hFFFC) begin
            n_err++;
            $display("FAIL wrap: got %h want FFFC", got);
        end
    endtask

    task automatic test_random();
        logic [15:0] got;
        for (int i = 0; i < 15; i++) begin
            for (int j = 0; j < int'($urandom_range(0, 4)); j++) begin
                write_coef(5'($urandom_range(0, 31)), 16'($urandom));
            end
            run_sample(16'($urandom), int'($urandom_range(0, 3)), got);
        end
    endtask

    initial begin
        m_reset();
        test_reset_idle();
        test_default_random();
        test_reset_mid_mac();
        test_single_tap();
        test_delay_align();
        test_back_to_back();
        test_write_busy();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
